// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store data port, one transaction at a time.
// Data requests win arbitration unless fetch has been passed over STARVE_LIMIT
// times in a row. A response that never arrives is turned into an error.
module core_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_err_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [3:0]        d_be_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic              mem_ready_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              timeout_flag_o
);

   localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam int TIMER_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                ownerFetch_q;
   logic                ifPendAtArb_q;
   logic [STREAK_W-1:0] streak_q;
   logic [TIMER_W-1:0]  timer_q;
   logic                memReq_q, memWe_q;
   logic [ADDR_W-1:0]   memAddr_q;
   logic [DATA_W-1:0]   memWdata_q;
   logic [3:0]          memBe_q;
   logic                ifRvalid_q, dRvalid_q, ifErr_q, dErr_q, timeoutFlag_q;
   logic [DATA_W-1:0]   ifRdata_q, dRdata_q;
   logic                pickFetch;
   logic                timerExpired;

   assign pickFetch    = if_req_i && (!d_req_i || (streak_q == STREAK_W'(STARVE_LIMIT)));
   assign timerExpired = (timer_q == TIMER_W'(TIMEOUT - 1));

   // State register; a reset drops any transaction in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state: arbitrate, wait for the memory to accept, then wait for the reply or the timer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (if_req_i || d_req_i) state_d = ISSUE;
         ISSUE:   if (mem_ready_i) state_d = WAIT;
         WAIT:    if (mem_rvalid_i || timerExpired) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transaction datapath: latch the winner's payload, track the fetch-starvation streak,
   // run the response timer and capture the response for a one-cycle pulse afterwards.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ownerFetch_q  <= 1'b0;
         ifPendAtArb_q <= 1'b0;
         streak_q      <= '0;
         timer_q       <= '0;
         memReq_q      <= 1'b0;
         memWe_q       <= 1'b0;
         memAddr_q     <= '0;
         memWdata_q    <= '0;
         memBe_q       <= 4'h0;
         ifRvalid_q    <= 1'b0;
         dRvalid_q     <= 1'b0;
         ifErr_q       <= 1'b0;
         dErr_q        <= 1'b0;
         ifRdata_q     <= '0;
         dRdata_q      <= '0;
         timeoutFlag_q <= 1'b0;
      end else begin
         ifRvalid_q <= 1'b0;
         dRvalid_q  <= 1'b0;
         ifErr_q    <= 1'b0;
         dErr_q     <= 1'b0;
         ifRdata_q  <= '0;
         dRdata_q   <= '0;
         case (state_q)
            IDLE: begin
               if (if_req_i || d_req_i) begin
                  ownerFetch_q  <= pickFetch;
                  ifPendAtArb_q <= if_req_i;
                  memReq_q      <= 1'b1;
                  if (pickFetch) begin
                     memWe_q    <= 1'b0;
                     memAddr_q  <= if_addr_i;
                     memWdata_q <= '0;
                     memBe_q    <= 4'hF;
                  end else begin
                     memWe_q    <= d_we_i;
                     memAddr_q  <= d_addr_i;
                     memWdata_q <= d_wdata_i;
                     memBe_q    <= d_be_i;
                  end
               end
            end
            ISSUE: begin
               if (mem_ready_i) begin
                  memReq_q <= 1'b0;
                  timer_q  <= '0;
                  if (ownerFetch_q || !ifPendAtArb_q)
                     streak_q <= '0;
                  else if (streak_q != STREAK_W'(STARVE_LIMIT))
                     streak_q <= streak_q + STREAK_W'(1);
               end
            end
            WAIT: begin
               timer_q <= timer_q + TIMER_W'(1);
               if (mem_rvalid_i) begin
                  if (ownerFetch_q) begin
                     ifRvalid_q <= 1'b1;
                     ifRdata_q  <= mem_rdata_i;
                  end else begin
                     dRvalid_q <= 1'b1;
                     dRdata_q  <= memWe_q ? '0 : mem_rdata_i;
                  end
               end else if (timerExpired) begin
                  timeoutFlag_q <= 1'b1;
                  if (ownerFetch_q) begin
                     ifRvalid_q <= 1'b1;
                     ifErr_q    <= 1'b1;
                  end else begin
                     dRvalid_q <= 1'b1;
                     dErr_q    <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: grants are decoded from ISSUE and mem_ready, everything else comes from registers.
   always_comb begin
      if_gnt_o       = (state_q == ISSUE) && mem_ready_i && ownerFetch_q;
      d_gnt_o        = (state_q == ISSUE) && mem_ready_i && !ownerFetch_q;
      if_rvalid_o    = ifRvalid_q;
      if_rdata_o     = ifRdata_q;
      if_err_o       = ifErr_q;
      d_rvalid_o     = dRvalid_q;
      d_rdata_o      = dRdata_q;
      d_err_o        = dErr_q;
      mem_req_o      = memReq_q;
      mem_we_o       = memWe_q;
      mem_addr_o     = memAddr_q;
      mem_wdata_o    = memWdata_q;
      mem_be_o       = memBe_q;
      timeout_flag_o = timeoutFlag_q;
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed checks of core_mem_arbiter with a short timeout
// (TIMEOUT=8) and the default starvation limit (STARVE_LIMIT=4).
module tb_core_mem_arbiter;

   logic        clk, reset;
   logic        ifReq, ifGnt, ifRvalid, ifErr;
   logic [31:0] ifAddr, ifRdata;
   logic        dReq, dWe, dGnt, dRvalid, dErr;
   logic [31:0] dAddr, dWdata, dRdata;
   logic [3:0]  dBe;
   logic        memReq, memWe, memReady, memRvalid;
   logic [31:0] memAddr, memWdata, memRdata;
   logic [3:0]  memBe;
   logic        timeoutFlag;

   int testCount = 0;
   int failCount = 0;

   core_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt),
      .if_rvalid_o(ifRvalid), .if_rdata_o(ifRdata), .if_err_o(ifErr),
      .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_be_i(dBe),
      .d_gnt_o(dGnt), .d_rvalid_o(dRvalid), .d_rdata_o(dRdata), .d_err_o(dErr),
      .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr),
      .mem_wdata_o(memWdata), .mem_be_o(memBe),
      .mem_ready_i(memReady), .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata),
      .timeout_flag_o(timeoutFlag)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive both requester ports in one go.
   task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                                input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be);
      ifReq = ir; ifAddr = ia; dReq = dr; dWe = we; dAddr = da; dWdata = wd; dBe = be;
   endtask

   // One full transaction from IDLE with one-cycle memory latency.
   task automatic runTxn(input logic expFetch, input logic [31:0] expAddr, input logic [31:0] memData,
                         input logic [31:0] expRdata, input string tag);
      step();
      checkOutput({tag, "_memreq"}, {31'd0, memReq}, 32'd1);
      checkOutput({tag, "_addr"}, memAddr, expAddr);
      memReady = 1'b1;
      #1;
      checkOutput({tag, "_ifgnt"}, {31'd0, ifGnt}, {31'd0, expFetch});
      checkOutput({tag, "_dgnt"}, {31'd0, dGnt}, {31'd0, !expFetch});
      step();
      memReady = 1'b0; memRvalid = 1'b1; memRdata = memData;
      step();
      memRvalid = 1'b0;
      checkOutput({tag, "_ifrvalid"}, {31'd0, ifRvalid}, {31'd0, expFetch});
      checkOutput({tag, "_drvalid"}, {31'd0, dRvalid}, {31'd0, !expFetch});
      checkOutput({tag, "_rdata"}, expFetch ? ifRdata : dRdata, expRdata);
      checkOutput({tag, "_err"}, {31'd0, ifErr | dErr}, 32'd0);
   endtask

   // Directed sequence: reset, mid-WAIT reset, priority, starvation, stalled store, timeout edges.
   initial begin
      reset = 1'b1;
      memReady = 1'b0; memRvalid = 1'b0; memRdata = '0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step(); step();
      checkOutput("rst_memreq", {31'd0, memReq}, 32'd0);
      checkOutput("rst_memaddr", memAddr, 32'd0);
      checkOutput("rst_rvalid", {30'd0, ifRvalid, dRvalid}, 32'd0);
      checkOutput("rst_flag", {31'd0, timeoutFlag}, 32'd0);
      reset = 1'b0;
      step();

      // Reset while waiting for a response to a load at 0x40.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
      step();
      checkOutput("t1_addr", memAddr, 32'h40);
      memReady = 1'b1;
      #1;
      checkOutput("t1_dgnt", {31'd0, dGnt}, 32'd1);
      step();
      memReady = 1'b0; dReq = 1'b0;
      step();
      reset = 1'b1;
      #1;
      checkOutput("t1_memreq", {31'd0, memReq}, 32'd0);
      checkOutput("t1_memaddr", memAddr, 32'd0);
      checkOutput("t1_membe", {28'd0, memBe}, 32'd0);
      checkOutput("t1_gnt", {30'd0, ifGnt, dGnt}, 32'd0);
      step();
      reset = 1'b0; memRvalid = 1'b1; memRdata = 32'h55;
      step();
      memRvalid = 1'b0;
      checkOutput("t1_late_rvalid", {30'd0, ifRvalid, dRvalid}, 32'd0);
      step();
      checkOutput("t1_late_rvalid2", {30'd0, ifRvalid, dRvalid}, 32'd0);

      // Simultaneous requests: data first, fetch next.
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      runTxn(1'b0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, "t2_load");
      dReq = 1'b0;
      runTxn(1'b1, 32'h200, 32'hCAFEF00D, 32'hCAFEF00D, "t2_fetch");
      checkOutput("t2_fetch_be", {28'd0, memBe}, 32'hF);
      ifReq = 1'b0;

      // Continuous data traffic with fetch waiting: four data grants, then fetch.
      applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
      for (int i = 0; i < 5; i++)
         runTxn(i == 4, (i == 4) ? 32'h400 : 32'h300, 32'h1000 + i, 32'h1000 + i, $sformatf("t3_g%0d", i));
      runTxn(1'b0, 32'h300, 32'h2222, 32'h2222, "t3_after");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();

      // Store stalled for three cycles by mem_ready.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h500, 32'h1234, 4'b0011);
      step();
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("t4_req%0d", i), {31'd0, memReq}, 32'd1);
         checkOutput($sformatf("t4_payload%0d", i), {memWdata[27:0], memBe}, {28'h0001234, 4'b0011});
         checkOutput($sformatf("t4_we%0d", i), {31'd0, memWe}, 32'd1);
         checkOutput($sformatf("t4_nognt%0d", i), {31'd0, dGnt}, 32'd0);
         step();
      end
      memReady = 1'b1;
      #1;
      checkOutput("t4_gnt", {31'd0, dGnt}, 32'd1);
      step();
      checkOutput("t4_req_drop", {31'd0, memReq}, 32'd0);
      memReady = 1'b0; dReq = 1'b0; dWe = 1'b0; memRvalid = 1'b1; memRdata = 32'hFFFFFFFF;
      step();
      memRvalid = 1'b0;
      checkOutput("t4_rvalid", {31'd0, dRvalid}, 32'd1);
      checkOutput("t4_rdata", dRdata, 32'd0);
      checkOutput("t4_err", {31'd0, dErr}, 32'd0);

      // Response arrives in the last cycle before expiry: normal response.
      applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      memReady = 1'b1;
      #1;
      checkOutput("t6_gnt", {31'd0, ifGnt}, 32'd1);
      step();
      memReady = 1'b0; ifReq = 1'b0;
      for (int i = 0; i < 7; i++) step();
      checkOutput("t6_pre_rvalid", {31'd0, ifRvalid}, 32'd0);
      memRvalid = 1'b1; memRdata = 32'hABCD;
      step();
      memRvalid = 1'b0;
      checkOutput("t6_rvalid", {31'd0, ifRvalid}, 32'd1);
      checkOutput("t6_err", {31'd0, ifErr}, 32'd0);
      checkOutput("t6_rdata", ifRdata, 32'hABCD);
      checkOutput("t6_flag", {31'd0, timeoutFlag}, 32'd0);
      step();

      // Fetch with no response: error after eight WAIT cycles, sticky flag.
      applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      memRdata = 32'h9999;
      step();
      memReady = 1'b1;
      #1;
      checkOutput("t5_gnt", {31'd0, ifGnt}, 32'd1);
      step();
      memReady = 1'b0; ifReq = 1'b0;
      for (int i = 0; i < 7; i++) step();
      checkOutput("t5_pre_rvalid", {31'd0, ifRvalid}, 32'd0);
      checkOutput("t5_pre_flag", {31'd0, timeoutFlag}, 32'd0);
      step();
      checkOutput("t5_rvalid", {31'd0, ifRvalid}, 32'd1);
      checkOutput("t5_err", {31'd0, ifErr}, 32'd1);
      checkOutput("t5_rdata", ifRdata, 32'd0);
      checkOutput("t5_flag", {31'd0, timeoutFlag}, 32'd1);
      step();
      checkOutput("t5_pulse_end", {31'd0, ifRvalid}, 32'd0);
      checkOutput("t5_flag_sticky", {31'd0, timeoutFlag}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("t5_flag_reset", {31'd0, timeoutFlag}, 32'd0);
      step();
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
